overture_io_queue: RTL
======================

# overture_io_queue

Buffered I/O port for the OVERTURE 8-bit CPU. Sits between the CPU's architectural I/O pins and the outside world. Output words the CPU emits are captured into an output FIFO and drained to a downstream sink over valid/ready. Words from an upstream source are queued into an input FIFO and presented to the CPU as its input value, popped when the CPU executes an input read.

## Interface
Parameters:
- DEPTH, 8, entries per FIFO; power of two, minimum 2
- WIDTH, 8, data width; must match the CPU word width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- arch_output_enable  in  1  CPU output strobe; word valid this cycle
- arch_output_value  in  WIDTH  CPU output word
- arch_input_enable  in  1  CPU input strobe; CPU consumes arch_input_value this cycle
- arch_input_value  out  WIDTH  head of input FIFO (first-word fall-through)
- out_valid  out  1  output FIFO non-empty
- out_data  out  WIDTH  output FIFO head
- out_ready  in  1  sink accepts out_data
- in_valid  in  1  source offers in_data
- in_data  in  WIDTH  source word
- in_ready  out  1  input FIFO not full
- out_count  out  $clog2(DEPTH)+1  output FIFO occupancy
- in_count  out  $clog2(DEPTH)+1  input FIFO occupancy
- overflow  out  1  sticky: CPU wrote while output FIFO full
- underflow  out  1  sticky: CPU read while input FIFO empty

## Operation
- Two independent circular FIFOs. Each has read/write pointers of $clog2(DEPTH) bits and an occupancy counter of $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Output push: arch_output_enable=1 at a clock edge.
- Output pop: out_valid & out_ready at a clock edge.
- Input push: in_valid & in_ready at a clock edge.
- Input pop: arch_input_enable=1 and in_count≠0.
- out_valid = (out_count≠0). out_data = mem[rd_ptr] when valid, else 0.
- in_ready = (in_count≠DEPTH) & ~rst.
- arch_input_value = input head when in_count≠0, else 0.
- Output full with push and pop in the same cycle: both occur, no overflow, count unchanged.
- Output full with push and no pop: word dropped, overflow←1.
- Input empty with arch_input_enable=1: arch_input_value=0, underflow←1. A simultaneous in_data push is stored (see Configuration).
- Input full with pop and push in the same cycle: in_ready=0, so no push that cycle. Pop proceeds.
- Sticky flags clear only on rst.
- Reset values: both counts 0, all pointers 0, out_valid 0, out_data 0, in_ready 0 during rst, arch_input_value 0, overflow 0, underflow 0. FIFO memory contents are not reset.
- rst mid-stream discards all queued words in both FIFOs.

## Timing
- Output latency: CPU word captured at edge N; out_valid=1 and out_data equal to that word from cycle N+1.
- Input latency: source word accepted at edge N; visible on arch_input_value from cycle N+1 if the FIFO was empty.
- arch_input_value is combinational from FIFO state only, never from arch_input_enable (no combinational loop into the CPU).
- Pops advance the head at the edge; the next word is visible the following cycle.
- Sustained throughput: one push and one pop per cycle per FIFO.

## Configuration
- OVERTURE_IOQ_BYPASS_EN defined: input FIFO empty, in_valid=1 and arch_input_enable=1 in the same cycle → arch_input_value=in_data combinationally. The word is consumed, not stored; no underflow; in_count stays 0.
- OVERTURE_IOQ_BYPASS_EN undefined: no bypass. That case reads 0, sets underflow, and stores in_data (in_count→1).

## Test plan
- Reset: hold rst 2 cycles → out_valid=0, in_ready=0, counts=0, flags=0, arch_input_value=0. Release → in_ready=1.
- Output stream: CPU writes 0x11,0x22,0x33 on consecutive cycles with out_ready=0 → out_count=3. Assert out_ready → out_data 0x11,0x22,0x33 on successive cycles, then out_valid=0.
- Output overflow: DEPTH=8, write 9 words with out_ready=0 → out_count=8, overflow=1, 9th word absent. Write while full with out_ready=1 → no new overflow event, count stays 8.
- Input path: push 0xA5, 0x5A → arch_input_value=0xA5. Pulse arch_input_enable → 0x5A next cycle, in_count=1.
- Underflow: arch_input_enable=1 with empty FIFO and in_valid=0 → arch_input_value=0, underflow=1 next cycle.
- Wrap/bypass: push/pop 20 words through DEPTH=8 checking order. Empty FIFO with in_valid=1, in_data=0x7E, arch_input_enable=1 → with the macro: value 0x7E, in_count=0. Without it: value 0, underflow=1, in_count=1.

Source files
------------

// File: rtl/overture_io_queue.sv
// Buffered CPU I/O port: an output FIFO drained over valid/ready and an input FIFO
// presented first-word fall-through. Optional feature macro: OVERTURE_IOQ_BYPASS_EN.
module overture_io_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arch_output_enable,
    input  logic [WIDTH-1:0]         arch_output_value,
    input  logic                     arch_input_enable,
    output logic [WIDTH-1:0]         arch_input_value,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic [$clog2(DEPTH):0]   in_count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = CW'(1'b1);
    localparam logic [AW-1:0] ZERO_PTR = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_PTR  = AW'(1'b1);

    logic [WIDTH-1:0] out_mem_r [DEPTH];
    logic [WIDTH-1:0] in_mem_r  [DEPTH];

    logic [AW-1:0] out_wr_ptr_r;
    logic [AW-1:0] out_rd_ptr_r;
    logic [CW-1:0] out_count_r;
    logic [AW-1:0] in_wr_ptr_r;
    logic [AW-1:0] in_rd_ptr_r;
    logic [CW-1:0] in_count_r;
    logic          overflow_r;
    logic          underflow_r;

    logic out_full_s;
    logic out_empty_s;
    logic out_push_s;
    logic out_pop_s;
    logic overflow_evt_s;
    logic in_full_s;
    logic in_empty_s;
    logic in_ready_s;
    logic in_push_s;
    logic in_pop_s;
    logic underflow_evt_s;
    logic bypass_avail_s;
    logic bypass_s;

    // Output FIFO handshake decode; a push into a full FIFO survives only alongside a pop.
    always_comb begin
        out_full_s     = (out_count_r == FULL_CNT);
        out_empty_s    = (out_count_r == ZERO_CNT);
        out_pop_s      = ~out_empty_s & out_ready;
        out_push_s     = arch_output_enable & (~out_full_s | out_pop_s);
        overflow_evt_s = arch_output_enable & out_full_s & ~out_pop_s;
    end

    // Input FIFO handshake decode, including the optional empty-FIFO bypass.
    always_comb begin
        in_full_s      = (in_count_r == FULL_CNT);
        in_empty_s     = (in_count_r == ZERO_CNT);
        in_ready_s     = ~in_full_s & ~rst;
`ifdef OVERTURE_IOQ_BYPASS_EN
        bypass_avail_s = in_empty_s & in_valid & ~rst;
`else
        bypass_avail_s = 1'b0;
`endif
        bypass_s        = bypass_avail_s & arch_input_enable;
        in_push_s       = in_valid & in_ready_s & ~bypass_s;
        in_pop_s        = arch_input_enable & ~in_empty_s;
        underflow_evt_s = arch_input_enable & in_empty_s & ~bypass_s;
    end

    // Output FIFO storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (out_push_s && !rst) begin
            out_mem_r[out_wr_ptr_r] <= arch_output_value;
        end else begin
            out_mem_r[out_wr_ptr_r] <= out_mem_r[out_wr_ptr_r];
        end
    end

    // Input FIFO storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (in_push_s) begin
            in_mem_r[in_wr_ptr_r] <= in_data;
        end else begin
            in_mem_r[in_wr_ptr_r] <= in_mem_r[in_wr_ptr_r];
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_wr_ptr_r <= ZERO_PTR;
            out_rd_ptr_r <= ZERO_PTR;
            out_count_r  <= ZERO_CNT;
        end else begin
            if (out_push_s) begin
                out_wr_ptr_r <= out_wr_ptr_r + ONE_PTR;
            end
            if (out_pop_s) begin
                out_rd_ptr_r <= out_rd_ptr_r + ONE_PTR;
            end
            case ({out_push_s, out_pop_s})
                2'b10:   out_count_r <= out_count_r + ONE_CNT;
                2'b01:   out_count_r <= out_count_r - ONE_CNT;
                default: out_count_r <= out_count_r;
            endcase
        end
    end

    // Input FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_wr_ptr_r <= ZERO_PTR;
            in_rd_ptr_r <= ZERO_PTR;
            in_count_r  <= ZERO_CNT;
        end else begin
            if (in_push_s) begin
                in_wr_ptr_r <= in_wr_ptr_r + ONE_PTR;
            end
            if (in_pop_s) begin
                in_rd_ptr_r <= in_rd_ptr_r + ONE_PTR;
            end
            case ({in_push_s, in_pop_s})
                2'b10:   in_count_r <= in_count_r + ONE_CNT;
                2'b01:   in_count_r <= in_count_r - ONE_CNT;
                default: in_count_r <= in_count_r;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r | overflow_evt_s;
            underflow_r <= underflow_r | underflow_evt_s;
        end
    end

    // Port drive; heads depend on FIFO state (and in_data for bypass), never on the CPU strobe.
    always_comb begin
        out_valid = ~out_empty_s;
        out_count = out_count_r;
        in_count  = in_count_r;
        in_ready  = in_ready_s;
        overflow  = overflow_r;
        underflow = underflow_r;
        if (!out_empty_s) begin
            out_data = out_mem_r[out_rd_ptr_r];
        end else begin
            out_data = {WIDTH{1'b0}};
        end
        if (!in_empty_s) begin
            arch_input_value = in_mem_r[in_rd_ptr_r];
        end else if (bypass_avail_s) begin
            arch_input_value = in_data;
        end else begin
            arch_input_value = {WIDTH{1'b0}};
        end
    end

endmodule
